// File: rtl/rvc_asap_pkg.sv
// rvc_asap_pkg: shared types and constants for the rvc_asap core's
// M-extension unit (operation codes, FSM state encoding, funct7 marker).
package rvc_asap_pkg;

  localparam logic [6:0] M_FUNCT7 = 7'b0000001;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } t_m_op;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } t_md_state;

endpackage

// File: rtl/rvc_asap_div_step.sv
// rvc_asap_div_step: one combinational restoring-division step.
// Shifts the next dividend bit into the partial remainder, trial-subtracts
// the divisor and shifts the resulting quotient bit into quo.
module rvc_asap_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] trial;
  logic [XLEN:0] diff;
  logic          fits;

  // trial subtract; rem < divisor always holds, so a clear borrow bit means
  // the difference fits in XLEN bits
  always_comb begin
    trial    = {rem, quo[XLEN-1]};
    diff     = trial - {1'b0, divisor};
    fits     = ~diff[XLEN];
    rem_next = fits ? diff[XLEN-1:0] : trial[XLEN-1:0];
    quo_next = {quo[XLEN-2:0], fits};
  end

endmodule

// File: rtl/rvc_asap_mul_div.sv
// rvc_asap_mul_div: iterative radix-2 RV M-extension unit.
// Build option RVC_ASAP_DIV_EN: when defined the divide datapath and its
// corner-case short-circuits are built; otherwise DIV/DIVU/REM/REMU complete
// one edge after accept with RspData=0 and RspIllegal=1.
//
// state | meaning
// IDLE  | ReqReady high, waiting for a request
// CALC  | one shift-add / shift-subtract step per cycle, cnt counts down
// DONE  | result held on RspData until RspReady
module rvc_asap_mul_div
  import rvc_asap_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            Clock,
  input  logic            Rst,
  input  logic            ReqValid,
  output logic            ReqReady,
  input  logic [2:0]      ReqOp,
  input  logic [XLEN-1:0] ReqRs1,
  input  logic [XLEN-1:0] ReqRs2,
  output logic            RspValid,
  input  logic            RspReady,
  output logic [XLEN-1:0] RspData,
  output logic            RspIllegal,
  output logic            Busy
);

  localparam int CW = $clog2(XLEN);

  t_md_state         state;
  t_m_op             op;
  t_m_op             req_op;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opb;
  logic              res_neg;

  logic              rs1_neg;
  logic              rs2_neg;
  logic              req_neg;
  logic [XLEN-1:0]   mag1;
  logic [XLEN-1:0]   mag2;
  logic              short_cut;
  logic              short_illegal;
  logic [XLEN-1:0]   short_data;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] step_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   calc_result;

  assign req_op = t_m_op'(ReqOp);

  // operand magnitudes and the sign the final result must carry
  always_comb begin
    rs1_neg = 1'b0;
    rs2_neg = 1'b0;
    case (req_op)
      MULH, DIV, REM: begin
        rs1_neg = ReqRs1[XLEN-1];
        rs2_neg = ReqRs2[XLEN-1];
      end
      MULHSU:  rs1_neg = ReqRs1[XLEN-1];
      default: ;
    endcase
    case (req_op)
      MULH, DIV:   req_neg = rs1_neg ^ rs2_neg;
      MULHSU, REM: req_neg = rs1_neg;
      default:     req_neg = 1'b0;
    endcase
    mag1 = rs1_neg ? -ReqRs1 : ReqRs1;
    mag2 = rs2_neg ? -ReqRs2 : ReqRs2;
  end

  // requests that skip CALC and go straight to DONE
  always_comb begin
    short_cut     = 1'b0;
    short_illegal = 1'b0;
    short_data    = '0;
`ifdef RVC_ASAP_DIV_EN
    if (ReqOp[2]) begin
      if (ReqRs2 == '0) begin
        short_cut  = 1'b1;
        short_data = ReqOp[1] ? ReqRs1 : '1;
      end else if (!ReqOp[0] && ReqRs1 == {1'b1, {(XLEN-1){1'b0}}} && ReqRs2 == '1) begin
        short_cut  = 1'b1;
        short_data = ReqOp[1] ? '0 : ReqRs1;
      end
    end
`else
    if (ReqOp[2]) begin
      short_cut     = 1'b1;
      short_illegal = 1'b1;
    end
`endif
  end

  // multiply: add multiplicand when the multiplier LSB is set, shift right
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);

`ifdef RVC_ASAP_DIV_EN
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;

  rvc_asap_div_step #(.XLEN(XLEN)) u_div_step (
    .rem      (acc[2*XLEN-1:XLEN]),
    .quo      (acc[XLEN-1:0]),
    .divisor  (opb),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  assign step_next = op[2] ? {rem_next, quo_next} : {mul_sum, acc[XLEN-1:1]};
`else
  assign step_next = {mul_sum, acc[XLEN-1:1]};
`endif

  // final sign fix and result selection, applied on the last CALC step
  always_comb begin
    prod        = res_neg ? -step_next : step_next;
    calc_result = (op == MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef RVC_ASAP_DIV_EN
    if (op[2]) begin
      if (op[1]) calc_result = res_neg ? -step_next[2*XLEN-1:XLEN] : step_next[2*XLEN-1:XLEN];
      else       calc_result = res_neg ? -step_next[XLEN-1:0] : step_next[XLEN-1:0];
    end
`endif
  end

  // control FSM with registered handshake outputs
  always_ff @(posedge Clock) begin
    if (Rst) begin
      state      <= IDLE;
      op         <= MUL;
      cnt        <= '0;
      acc        <= '0;
      opb        <= '0;
      res_neg    <= 1'b0;
      ReqReady   <= 1'b1;
      RspValid   <= 1'b0;
      RspData    <= '0;
      RspIllegal <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ReqValid && ReqReady) begin
            op         <= req_op;
            res_neg    <= req_neg;
            cnt        <= CW'(XLEN-1);
            acc        <= {{XLEN{1'b0}}, (ReqOp[2] ? mag1 : mag2)};
            opb        <= ReqOp[2] ? mag2 : mag1;
            ReqReady   <= 1'b0;
            Busy       <= 1'b1;
            RspIllegal <= short_illegal;
            if (short_cut) begin
              state    <= DONE;
              RspValid <= 1'b1;
              RspData  <= short_data;
            end else begin
              state    <= CALC;
            end
          end
        end
        CALC: begin
          acc <= step_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state    <= DONE;
            RspValid <= 1'b1;
            RspData  <= calc_result;
          end
        end
        DONE: begin
          if (RspReady) begin
            state    <= IDLE;
            RspValid <= 1'b0;
            ReqReady <= 1'b1;
            Busy     <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          RspValid <= 1'b0;
          ReqReady <= 1'b1;
          Busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rvc_asap_mul_div.sv
// tb_rvc_asap_mul_div: self-checking bench for rvc_asap_mul_div (XLEN=32).
// Expected results come from a plain-arithmetic model of the RV M ops;
// a compare process checks every cycle the response is valid.
module tb_rvc_asap_mul_div;
  localparam int XLEN = 32;
`ifdef RVC_ASAP_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Rst = 1'b1;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic [2:0]  ReqOp = 3'd0;
  logic [31:0] ReqRs1 = '0;
  logic [31:0] ReqRs2 = '0;
  logic        RspValid;
  logic        RspReady = 1'b0;
  logic [31:0] RspData;
  logic        RspIllegal;
  logic        Busy;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_data = '0;
  logic        exp_ill = 1'b0;
  bit          exp_armed = 1'b0;

  rvc_asap_mul_div #(.XLEN(XLEN)) dut (
    .Clock      (Clock),
    .Rst        (Rst),
    .ReqValid   (ReqValid),
    .ReqReady   (ReqReady),
    .ReqOp      (ReqOp),
    .ReqRs1     (ReqRs1),
    .ReqRs2     (ReqRs2),
    .RspValid   (RspValid),
    .RspReady   (RspReady),
    .RspData    (RspData),
    .RspIllegal (RspIllegal),
    .Busy       (Busy)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {illegal, data} for one operation, straight from the ISA definition
  function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    logic [31:0] r;
    bit          ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: r = (b == 0) ? a : a % b;
    endcase
    if (!DIV_EN && op[2]) return {1'b1, 32'h0};
    return {1'b0, r};
  endfunction

  // edges from accept (counted as edge 1) until RspValid is seen high
  function automatic int lat_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2]) begin
      if (!DIV_EN) return 1;
      if (b == 0) return 1;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    end
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] lit_sel(input logic [2:0] op, input logic [31:0] v);
    return (!DIV_EN && op[2]) ? 32'h0 : v;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // response checks on every cycle the result is presented
  always @(negedge Clock) begin
    if (exp_armed && RspValid) begin
      chk("rsp_data", RspData, exp_data);
      chk("rsp_illegal", RspIllegal, exp_ill);
      chk("req_ready_done", ReqReady, 0);
      chk("busy_done", Busy, 1);
    end
  end

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit use_lit, input logic [31:0] lit);
    logic [32:0] m;
    int          edges;
    int          exp_lat;
    m       = model(op, a, b);
    exp_lat = lat_model(op, a, b);
    @(negedge Clock);
    chk("req_ready_idle", ReqReady, 1);
    ReqValid = 1'b1;
    ReqOp    = op;
    ReqRs1   = a;
    ReqRs2   = b;
    @(posedge Clock);
    #1;
    ReqValid  = 1'b0;
    exp_data  = m[31:0];
    exp_ill   = m[32];
    exp_armed = 1'b1;
    edges     = 1;
    @(negedge Clock);
    while (!RspValid && edges < 200) begin
      ReqValid = 1'($urandom);
      ReqOp    = 3'($urandom);
      ReqRs1   = $urandom;
      ReqRs2   = $urandom;
      @(posedge Clock);
      edges++;
      @(negedge Clock);
    end
    ReqValid = 1'b0;
    chk("latency", edges, exp_lat);
    if (use_lit) chk("lit_data", RspData, lit);
    for (int i = 0; i < hold; i++) begin
      @(posedge Clock);
      @(negedge Clock);
      chk("hold_valid", RspValid, 1);
    end
    RspReady = 1'b1;
    @(posedge Clock);
    #1;
    RspReady  = 1'b0;
    exp_armed = 1'b0;
    @(negedge Clock);
    chk("rsp_valid_drop", RspValid, 0);
    chk("req_ready_back", ReqReady, 1);
    chk("busy_clear", Busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int stale;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("rst_req_ready", ReqReady, 1);
    chk("rst_rsp_valid", RspValid, 0);
    chk("rst_rsp_data", RspData, 0);
    chk("rst_rsp_illegal", RspIllegal, 0);
    chk("rst_busy", Busy, 0);
    Rst = 1'b0;

    do_op(3'd0, 32'd7, 32'd6, 0, 1, 32'd42);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'h0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFE);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFF);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 1, lit_sel(3'd4, 32'hFFFF_FFFD));
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 1, lit_sel(3'd6, 32'hFFFF_FFFF));
    do_op(3'd5, 32'd5, 32'd0, 0, 1, lit_sel(3'd5, 32'hFFFF_FFFF));
    do_op(3'd7, 32'd5, 32'd0, 0, 1, lit_sel(3'd7, 32'd5));
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, lit_sel(3'd4, 32'h8000_0000));
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, lit_sel(3'd6, 32'h0));
    do_op(3'd5, 32'd100, 32'd7, 0, 1, lit_sel(3'd5, 32'd14));
    do_op(3'd7, 32'd100, 32'd7, 0, 1, lit_sel(3'd7, 32'd2));

    // backpressure: result held for five cycles
    do_op(3'd0, 32'd7, 32'd6, 5, 1, 32'd42);

    // reset while CALC is at cnt=10
    @(negedge Clock);
    ReqValid = 1'b1;
    ReqOp    = 3'd0;
    ReqRs1   = 32'd123;
    ReqRs2   = 32'd456;
    @(posedge Clock);
    #1;
    ReqValid = 1'b0;
    repeat (21) @(posedge Clock);
    @(negedge Clock);
    Rst = 1'b1;
    @(posedge Clock);
    #1;
    Rst = 1'b0;
    @(negedge Clock);
    chk("midrst_req_ready", ReqReady, 1);
    chk("midrst_rsp_valid", RspValid, 0);
    chk("midrst_busy", Busy, 0);
    chk("midrst_rsp_data", RspData, 0);
    chk("midrst_rsp_illegal", RspIllegal, 0);
    stale = 0;
    repeat (40) begin
      @(negedge Clock);
      if (RspValid) stale++;
    end
    chk("midrst_no_stale", stale, 0);

    for (int n = 0; n < 250; n++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 3'($urandom);
      a  = pick();
      b  = pick();
      do_op(op, a, b, $urandom_range(0, 3), 0, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
